// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, register-file geometry and the
// write-back control bundle carried through the EX/MEM and MEM/WB registers.
package pipe_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_regfile_if.sv
// MEM/WB-to-write-back bundle plus the decode-stage read ports of the register file.
// The master side is the pipeline (drives MEM/WB values and read indices).
interface wb_stage_regfile_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic              regwrite_in;
  logic              memtoreg_in;
  logic [DATA_W-1:0] mem_rdata_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [ADDR_W-1:0] rd_in;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;

  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output regwrite_in, memtoreg_in, mem_rdata_in, alu_result_in, rd_in,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_en, wb_rd, wb_data, wb_count
  );

  modport slave (
    input  regwrite_in, memtoreg_in, mem_rdata_in, alu_result_in, rd_in,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_en, wb_rd, wb_data, wb_count
  );

endinterface

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with x0 hardwired to zero and an optional
// write-first bypass so decode sees a same-cycle write-back without stalling.
module regfile_2r1w
  import pipe_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;

  // Writes are suppressed while reset is held so neither the array nor the bypass sees them.
  assign wr_ok = we && !reset && (waddr != ZERO_REG);

  // NOTE: the array is cleared by the asynchronous reset because a mid-stream
  // reset must make every register read zero immediately; that rules out a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // NOTE: every output gets a default first so no path through the mux infers a latch.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (BYPASS_EN && wr_ok && (raddr1 == waddr)) rdata1 = wdata;
    if (BYPASS_EN && wr_ok && (raddr2 == waddr)) rdata2 = wdata;
    if (raddr1 == ZERO_REG) rdata1 = '0;
    if (raddr2 == ZERO_REG) rdata2 = '0;
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: selects load data or ALU result, qualifies the write against x0,
// writes the register file and counts qualified write-back events.
module wb_stage_regfile
  import pipe_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  wb_stage_regfile_if.slave   bus
);

  wb_ctrl_t          ctrl;
  logic              wb_en;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  wb_count;

  assign ctrl.regwrite = bus.regwrite_in;
  assign ctrl.memtoreg = bus.memtoreg_in;

  assign wb_data = ctrl.memtoreg ? bus.mem_rdata_in : bus.alu_result_in;
  assign wb_en   = ctrl.regwrite && (bus.rd_in != ZERO_REG);

  assign bus.wb_en    = wb_en;
  assign bus.wb_rd    = bus.rd_in;
  assign bus.wb_data  = wb_data;
  assign bus.wb_count = wb_count;

  // Free-running modulo counter: wraps to zero with no saturation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      wb_count <= '0;
    else if (wb_en) wb_count <= wb_count + CNT_W'(1);
  end

  regfile_2r1w #(
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (bus.rd_in),
    .wdata  (wb_data),
    .raddr1 (bus.rs1_addr),
    .raddr2 (bus.rs2_addr),
    .rdata1 (bus.rs1_data),
    .rdata2 (bus.rs2_data)
  );

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed bench for wb_stage_regfile: a bypassing and a non-bypassing instance
// share the same stimulus and are compared against spec-derived values.
module tb_wb_stage_regfile;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wb_stage_regfile_if bus ();
  wb_stage_regfile_if bus_nb ();

  assign bus_nb.regwrite_in   = bus.regwrite_in;
  assign bus_nb.memtoreg_in   = bus.memtoreg_in;
  assign bus_nb.mem_rdata_in  = bus.mem_rdata_in;
  assign bus_nb.alu_result_in = bus.alu_result_in;
  assign bus_nb.rd_in         = bus.rd_in;
  assign bus_nb.rs1_addr      = bus.rs1_addr;
  assign bus_nb.rs2_addr      = bus.rs2_addr;

  wb_stage_regfile #(.BYPASS_EN(1'b1), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wb_stage_regfile #(.BYPASS_EN(1'b0), .CNT_W(16)) dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    reset             = 1'b1;
    bus.regwrite_in   = 1'b0;
    bus.memtoreg_in   = 1'b0;
    bus.mem_rdata_in  = '0;
    bus.alu_result_in = '0;
    bus.rd_in         = '0;
    bus.rs1_addr      = '0;
    bus.rs2_addr      = '0;

    // 1: reset for two cycles, then every index reads zero
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(31 - i);
      #1;
      check("reset_rs1", bus.rs1_data, 32'h0);
      check("reset_rs2", bus.rs2_data, 32'h0);
    end
    check("reset_count", {16'd0, bus.wb_count}, 32'h0);
    check("reset_wb_en", {31'd0, bus.wb_en}, 32'h0);

    // 2: ALU write to r5, read back next cycle
    step();
    bus.regwrite_in   = 1'b1;
    bus.memtoreg_in   = 1'b0;
    bus.alu_result_in = 32'h0000_1234;
    bus.mem_rdata_in  = 32'h0000_0055;
    bus.rd_in         = 5'd5;
    #1;
    check("alu_wb_en", {31'd0, bus.wb_en}, 32'h1);
    check("alu_wb_rd", {27'd0, bus.wb_rd}, 32'h5);
    check("alu_wb_data", bus.wb_data, 32'h0000_1234);
    step();
    bus.regwrite_in = 1'b0;
    bus.rs1_addr    = 5'd5;
    #1;
    check("r5_read", bus.rs1_data, 32'h0000_1234);
    check("r5_read_nb", bus_nb.rs1_data, 32'h0000_1234);
    check("count_after_r5", {16'd0, bus.wb_count}, 32'h1);

    // 3: load write to r7 read on both ports the same cycle
    step();
    bus.regwrite_in   = 1'b1;
    bus.memtoreg_in   = 1'b1;
    bus.mem_rdata_in  = 32'hDEAD_BEEF;
    bus.alu_result_in = 32'h0000_1111;
    bus.rd_in         = 5'd7;
    bus.rs1_addr      = 5'd7;
    bus.rs2_addr      = 5'd7;
    #1;
    check("load_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    check("bypass_rs1", bus.rs1_data, 32'hDEAD_BEEF);
    check("bypass_rs2", bus.rs2_data, 32'hDEAD_BEEF);
    check("nobypass_rs1_old", bus_nb.rs1_data, 32'h0);
    check("nobypass_rs2_old", bus_nb.rs2_data, 32'h0);
    step();
    bus.regwrite_in = 1'b0;
    #1;
    check("r7_rs1", bus.rs1_data, 32'hDEAD_BEEF);
    check("nobypass_rs1_new", bus_nb.rs1_data, 32'hDEAD_BEEF);
    check("nobypass_rs2_new", bus_nb.rs2_data, 32'hDEAD_BEEF);
    check("count_after_r7", {16'd0, bus.wb_count}, 32'h2);

    // 4: write to x0 is dropped, bypass never returns it
    step();
    bus.regwrite_in   = 1'b1;
    bus.memtoreg_in   = 1'b0;
    bus.alu_result_in = 32'hFFFF_FFFF;
    bus.rd_in         = 5'd0;
    bus.rs1_addr      = 5'd0;
    bus.rs2_addr      = 5'd5;
    #1;
    check("x0_wb_en", {31'd0, bus.wb_en}, 32'h0);
    check("x0_wb_data", bus.wb_data, 32'hFFFF_FFFF);
    check("x0_same_cycle", bus.rs1_data, 32'h0);
    check("x0_same_cycle_nb", bus_nb.rs1_data, 32'h0);
    check("r5_held", bus.rs2_data, 32'h0000_1234);
    step();
    bus.regwrite_in = 1'b0;
    #1;
    check("x0_next_cycle", bus.rs1_data, 32'h0);
    check("count_after_x0", {16'd0, bus.wb_count}, 32'h2);

    // 5: write r3, then a reset pulse between edges clears it immediately
    step();
    bus.regwrite_in   = 1'b1;
    bus.alu_result_in = 32'hA5A5_A5A5;
    bus.rd_in         = 5'd3;
    step();
    bus.regwrite_in = 1'b0;
    bus.rs1_addr    = 5'd3;
    bus.rs2_addr    = 5'd5;
    #1;
    check("r3_before_reset", bus.rs1_data, 32'hA5A5_A5A5);
    check("count_before_reset", {16'd0, bus.wb_count}, 32'h3);
    reset             = 1'b1;
    bus.regwrite_in   = 1'b1;
    bus.alu_result_in = 32'h0000_0077;
    #1;
    check("r3_in_reset", bus.rs1_data, 32'h0);
    check("r5_in_reset", bus.rs2_data, 32'h0);
    check("r3_in_reset_nb", bus_nb.rs1_data, 32'h0);
    check("count_in_reset", {16'd0, bus.wb_count}, 32'h0);
    reset           = 1'b0;
    bus.regwrite_in = 1'b0;
    #1;
    check("r3_after_reset", bus.rs1_data, 32'h0);
    check("count_after_reset", {16'd0, bus.wb_count}, 32'h0);

    // 6: 0xFFFE writes to r1, then two more to r2 to wrap the counter
    step();
    bus.regwrite_in   = 1'b1;
    bus.memtoreg_in   = 1'b0;
    bus.rd_in         = 5'd1;
    bus.alu_result_in = 32'd0;
    for (int n = 1; n < 32'hFFFE; n++) begin
      step();
      bus.alu_result_in = 32'(n);
    end
    step();
    bus.regwrite_in = 1'b0;
    bus.rs1_addr    = 5'd1;
    bus.rs2_addr    = 5'd2;
    #1;
    check("count_fffe", {16'd0, bus.wb_count}, 32'h0000_FFFE);
    check("r1_last", bus.rs1_data, 32'h0000_FFFD);
    step();
    bus.regwrite_in   = 1'b1;
    bus.rd_in         = 5'd2;
    bus.alu_result_in = 32'h0000_BEEF;
    step();
    bus.regwrite_in = 1'b0;
    #1;
    check("count_ffff", {16'd0, bus.wb_count}, 32'h0000_FFFF);
    check("r2_first", bus.rs2_data, 32'h0000_BEEF);
    step();
    bus.regwrite_in   = 1'b1;
    bus.alu_result_in = 32'h0000_CAFE;
    step();
    bus.regwrite_in = 1'b0;
    #1;
    check("count_wrap", {16'd0, bus.wb_count}, 32'h0);
    check("r2_second", bus.rs2_data, 32'h0000_CAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
